// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame length checker.
//   state_e   : frame tracking FSM states
//   LEN_W_DEF : default width of the per-frame beat counter
//   CNT_W_DEF : default width of the statistics counters
//   sat_inc() : increment that sticks at the all-ones value of a given width
package frame_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  localparam int LEN_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  // Works on a 64-bit container so one function serves every width; callers
  // zero-extend their value in and truncate the result back to their width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value == max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/frame_sat_counter.sv
// Saturating event counter.
//   clk    : clock
//   arst_n : asynchronous active-low reset, clears the count
//   inc    : add one this cycle (ignored once the count is all-ones)
//   count  : current count
module frame_sat_counter
  import frame_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = W'(sat_inc(64'(count_q), unsigned'(W)));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/frame_len_checker.sv
// Frame length checker: forwards a valid/sop/eop beat stream through one
// register stage, measures each frame's length in beats, flags frames outside
// [MIN_LEN, MAX_LEN] and keeps saturating statistics.
//   i_clk, i_arst_n            : clock, asynchronous active-low reset
//   i_valid, i_sop, i_eop      : input beat stream (sop/eop qualified by valid)
//   o_valid, o_sop, o_eop      : input stream delayed one cycle, sop/eop masked
//   o_lenValid                 : one-cycle report pulse, aligned with o_eop
//   o_len, o_errShort/Long     : report payload, held between reports
//   o_frame/short/long/abortCount : saturating statistics counters
module frame_len_checker
  import frame_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_valid,
  input  logic             i_sop,
  input  logic             i_eop,
  output logic             o_valid,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_lenValid,
  output logic [LEN_W-1:0] o_len,
  output logic             o_errShort,
  output logic             o_errLong,
  output logic [CNT_W-1:0] o_frameCount,
  output logic [CNT_W-1:0] o_shortCount,
  output logic [CNT_W-1:0] o_longCount,
  output logic [CNT_W-1:0] o_abortCount
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             valid_q, sop_q, eop_q;
  logic             len_valid_q, err_short_q, err_long_q;
  logic [LEN_W-1:0] out_len_q;

  logic             sop_v, eop_v;
  logic [LEN_W-1:0] len_inc;
  logic             report;
  logic [LEN_W-1:0] rpt_len;
  logic             rpt_short, rpt_long;
  logic             abort;

  assign sop_v   = i_valid & i_sop;
  assign eop_v   = i_valid & i_eop;
  assign len_inc = LEN_W'(sat_inc(64'(len_q), unsigned'(LEN_W)));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    report  = 1'b0;
    rpt_len = len_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Beats without sop outside a frame are ignored.
        if (sop_v) begin
          if (eop_v) begin
            report  = 1'b1;
            rpt_len = ONE_L;
            len_d   = '0;
          end else begin
            len_d   = ONE_L;
            state_d = IN_FRAME;
          end
        end
      end
      IN_FRAME: begin
        if (sop_v) begin
          // A new sop kills the open frame; the new frame starts at this beat.
          abort = 1'b1;
          if (eop_v) begin
            report  = 1'b1;
            rpt_len = ONE_L;
            len_d   = '0;
            state_d = IDLE;
          end else begin
            len_d   = ONE_L;
          end
        end else if (eop_v) begin
          report  = 1'b1;
          rpt_len = len_inc;
          len_d   = '0;
          state_d = IDLE;
        end else if (i_valid) begin
          len_d = len_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A saturated length is always above MAX_LEN, so it reports as long.
  assign rpt_short = rpt_len < MIN_L;
  assign rpt_long  = rpt_len > MAX_L;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      len_valid_q <= 1'b0;
      out_len_q   <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      valid_q     <= i_valid;
      sop_q       <= sop_v;
      eop_q       <= eop_v;
      len_valid_q <= report;
      if (report) begin
        out_len_q   <= rpt_len;
        err_short_q <= rpt_short;
        err_long_q  <= rpt_long;
      end
    end
  end

  // Counters are fed from the same-cycle report decision so their update
  // lands on the edge that raises o_lenValid.
  frame_sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk(i_clk), .arst_n(i_arst_n), .inc(report), .count(o_frameCount)
  );
  frame_sat_counter #(.W(CNT_W)) u_short_cnt (
    .clk(i_clk), .arst_n(i_arst_n), .inc(report & rpt_short), .count(o_shortCount)
  );
  frame_sat_counter #(.W(CNT_W)) u_long_cnt (
    .clk(i_clk), .arst_n(i_arst_n), .inc(report & rpt_long), .count(o_longCount)
  );
  frame_sat_counter #(.W(CNT_W)) u_abort_cnt (
    .clk(i_clk), .arst_n(i_arst_n), .inc(abort), .count(o_abortCount)
  );

  assign o_valid    = valid_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_lenValid = len_valid_q;
  assign o_len      = out_len_q;
  assign o_errShort = err_short_q;
  assign o_errLong  = err_long_q;

endmodule

// File: tb/tb_frame_len_checker.sv
// Directed bench for frame_len_checker. u_dut uses default parameters;
// u_sat (LEN_W=4, MAX_LEN=10, CNT_W=2) shares the same stimulus and is
// checked only where length or counter saturation is exercised.
module tb_frame_len_checker;

  logic        clk;
  logic        rst_n;
  logic        i_valid, i_sop, i_eop;

  logic        o_valid, o_sop, o_eop, o_lenValid, o_errShort, o_errLong;
  logic [15:0] o_len;
  logic [31:0] o_frameCount, o_shortCount, o_longCount, o_abortCount;

  logic        s_valid, s_sop, s_eop, s_lenValid, s_errShort, s_errLong;
  logic [3:0]  s_len;
  logic [1:0]  s_frameCount, s_shortCount, s_longCount, s_abortCount;

  frame_len_checker u_dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop),
    .o_lenValid(o_lenValid), .o_len(o_len),
    .o_errShort(o_errShort), .o_errLong(o_errLong),
    .o_frameCount(o_frameCount), .o_shortCount(o_shortCount),
    .o_longCount(o_longCount), .o_abortCount(o_abortCount)
  );

  frame_len_checker #(.LEN_W(4), .MIN_LEN(2), .MAX_LEN(10), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .o_valid(s_valid), .o_sop(s_sop), .o_eop(s_eop),
    .o_lenValid(s_lenValid), .o_len(s_len),
    .o_errShort(s_errShort), .o_errLong(s_errLong),
    .o_frameCount(s_frameCount), .o_shortCount(s_shortCount),
    .o_longCount(s_longCount), .o_abortCount(s_abortCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e);
    i_valid = v;
    i_sop   = s;
    i_eop   = e;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  o_valid, 0);
    check({tag, "_sop"},    o_sop, 0);
    check({tag, "_eop"},    o_eop, 0);
    check({tag, "_lenv"},   o_lenValid, 0);
    check({tag, "_len"},    o_len, 0);
    check({tag, "_short"},  o_errShort, 0);
    check({tag, "_long"},   o_errLong, 0);
    check({tag, "_frames"}, o_frameCount, 0);
    check({tag, "_shorts"}, o_shortCount, 0);
    check({tag, "_longs"},  o_longCount, 0);
    check({tag, "_aborts"}, o_abortCount, 0);
    check({tag, "_s_lenv"}, s_lenValid, 0);
    check({tag, "_s_len"},  s_len, 0);
    check({tag, "_s_frm"},  s_frameCount, 0);
  endtask

  typedef struct {
    logic       v, s, e;     // beat applied
    logic       lv;          // expected o_lenValid after the edge
    logic [15:0] len;        // expected o_len when lv
    logic       sh, lg;      // expected flags when lv
    int         frames;      // expected o_frameCount after the edge
    int         aborts;      // expected o_abortCount after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, s, e, lv, input int len,
                              input logic sh, lg, input int frames, aborts);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.lv = lv; r.len = 16'(len);
    r.sh = sh; r.lg = lg; r.frames = frames; r.aborts = aborts;
    return r;
  endfunction

  initial begin
    int reports;
    logic [15:0] cap_len;
    logic cap_sh, cap_lg;
    logic prev_v, prev_s, prev_e;

    drive(0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    rst_n = 1'b1;

    // 5-beat frame
    vecs.push_back(mk(1,1,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1, 1,5,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,0));
    // single-beat frame is short
    vecs.push_back(mk(1,1,1, 1,1,1,0, 2,0));
    // back-to-back: 2-beat, 3-beat, then a 1-beat right after eop
    vecs.push_back(mk(1,1,0, 0,0,0,0, 2,0));
    vecs.push_back(mk(1,0,1, 1,2,0,0, 3,0));
    vecs.push_back(mk(1,1,0, 0,0,0,0, 3,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 3,0));
    vecs.push_back(mk(1,0,1, 1,3,0,0, 4,0));
    vecs.push_back(mk(1,1,1, 1,1,1,0, 5,0));
    // stray beats in IDLE, and sop/eop without valid
    vecs.push_back(mk(1,0,1, 0,0,0,0, 5,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,0));
    vecs.push_back(mk(0,1,1, 0,0,0,0, 5,0));
    // abort: 4 beats, then a new sop starting a 5-beat frame
    vecs.push_back(mk(1,1,0, 0,0,0,0, 5,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,0));
    vecs.push_back(mk(1,1,0, 0,0,0,0, 5,1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 5,1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5,1));
    vecs.push_back(mk(1,0,1, 1,5,0,0, 6,1));
    // sop&eop inside a frame: abort plus a 1-beat report
    vecs.push_back(mk(1,1,0, 0,0,0,0, 6,1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 6,1));
    vecs.push_back(mk(1,1,1, 1,1,1,0, 7,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 7,2));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].e);
      tick();
      check($sformatf("v%0d_valid", i), o_valid, vecs[i].v);
      check($sformatf("v%0d_sop", i), o_sop, vecs[i].v & vecs[i].s);
      check($sformatf("v%0d_eop", i), o_eop, vecs[i].v & vecs[i].e);
      check($sformatf("v%0d_lenv", i), o_lenValid, vecs[i].lv);
      if (vecs[i].lv) begin
        check($sformatf("v%0d_len", i), o_len, vecs[i].len);
        check($sformatf("v%0d_short", i), o_errShort, vecs[i].sh);
        check($sformatf("v%0d_long", i), o_errLong, vecs[i].lg);
      end
      check($sformatf("v%0d_frames", i), o_frameCount, vecs[i].frames);
      check($sformatf("v%0d_aborts", i), o_abortCount, vecs[i].aborts);
    end
    check("tbl_len_hold", o_len, 1);
    check("tbl_shorts", o_shortCount, 3);
    check("tbl_longs", o_longCount, 0);

    // 70 valid beats with an idle cycle every third cycle
    reports = 0; cap_len = '0; cap_sh = 1'b0; cap_lg = 1'b0;
    begin
      int beats = 0;
      int cyc = 0;
      while (beats < 70) begin
        if (cyc % 3 == 2) begin
          drive(0, 0, 0);
        end else begin
          drive(1, beats == 0, beats == 69);
          beats++;
        end
        prev_v = i_valid;
        tick();
        check("long_pt_valid", o_valid, prev_v);
        if (o_lenValid) begin
          reports++;
          cap_len = o_len; cap_sh = o_errShort; cap_lg = o_errLong;
        end
        cyc++;
      end
    end
    drive(0, 0, 0);
    tick();
    check("long_pulse_once", o_lenValid, 0);
    check("long_reports", reports, 1);
    check("long_len", cap_len, 70);
    check("long_errLong", cap_lg, 1);
    check("long_errShort", cap_sh, 0);
    check("long_longs", o_longCount, 1);
    check("long_frames", o_frameCount, 8);

    // Reset in the middle of a 10-beat frame discards it
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_async");
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    reports = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1, 0, i == 4);
      else       drive(0, 0, 0);
      tick();
      if (o_lenValid || s_lenValid) reports++;
    end
    check("midrst_no_report", reports, 0);
    check("midrst_frames", o_frameCount, 0);
    check("midrst_aborts", o_abortCount, 0);

    // 20-beat frame: main reports 20 clean, LEN_W=4 instance saturates at 15
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, i == 19);
      prev_s = i_sop; prev_e = i_eop;
      tick();
      if (i == 0) check("sat_pt_sop", o_sop, prev_s);
    end
    check("sat_pt_eop", s_eop, prev_e);
    check("sat_lenv", s_lenValid, 1);
    check("sat_len", s_len, 15);
    check("sat_errLong", s_errLong, 1);
    check("sat_errShort", s_errShort, 0);
    check("sat_longs", s_longCount, 1);
    check("main20_len", o_len, 20);
    check("main20_errLong", o_errLong, 0);

    // Five single-beat frames saturate the 2-bit counters
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1);
      tick();
      check("sat1_lenv", s_lenValid, 1);
      check("sat1_short", s_errShort, 1);
    end
    drive(0, 0, 0);
    tick();
    check("sat_frames", s_frameCount, 3);
    check("sat_shorts", s_shortCount, 3);
    check("sat_longs_hold", s_longCount, 1);
    check("main_frames6", o_frameCount, 6);
    check("main_shorts5", o_shortCount, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
